// File: rtl/shared_counters_host.sv
// shared_counters_host
// Client-side command initiator for the shared counter pool. It takes one
// request at a time and drives the pool command bus. For a new-counter
// request it captures the returned allocation id. For a read request it
// reassembles the serialized read stream, LSB-first, into one 64-bit word.
// Every accepted request ends in exactly one response.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   req_*            request channel (valid/ready): op, id, size, load data
//   rsp_*            response channel (valid/ready): op, data, error flag
//   cmd, cmd_id,     pool command bus
//   cmd_size,
//   load_data,
//   load_valid
//   alloc_id/valid   allocation id returned by the pool
//   rdata*           serialized read stream from the pool, G bits per beat
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready for a request
// ISSUE      | command presented to the pool for one cycle
// WAIT_ALLOC | waiting for the pool to return an allocation id
// COLLECT    | gathering read beats until last, overflow or timeout
// RESP       | response held until the client accepts it
module shared_counters_host #(
    parameter int N          = 10,
    parameter int G          = 4,
    parameter int TIMEOUT    = 16,
    localparam int IDW       = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_op,
    input  logic [IDW-1:0] req_id,
    input  logic [IDW:0]   req_size,
    input  logic [63:0]    req_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2:0]     rsp_op,
    output logic [63:0]    rsp_data,
    output logic           rsp_err,
    output logic [2:0]     cmd,
    output logic [IDW-1:0] cmd_id,
    output logic [IDW:0]   cmd_size,
    output logic [63:0]    load_data,
    output logic           load_valid,
    input  logic [IDW:0]   alloc_id,
    input  logic           alloc_valid,
    input  logic [G-1:0]   rdata,
    input  logic           rdata_valid,
    input  logic           rdata_last
);

    localparam int BEATS = 64 / G;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] BEATS_MAX = BCW'(BEATS);
    // Timer runs TIMEOUT cycles: loaded with TIMEOUT-1, expires at zero.
    localparam logic [TW-1:0]  T_LOAD    = TW'(TIMEOUT - 1);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_NEW  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_READ = 3'b101;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ALLOC, COLLECT, RESP} state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [BCW-1:0] beat_cnt;
    logic [TW-1:0]  timer;
    logic           legal_op;

    assign legal_op = (req_op >= OP_INC) && (req_op <= OP_READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_NONE;
            beat_cnt   <= '0;
            timer      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_op     <= OP_NONE;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            cmd        <= OP_NONE;
            cmd_id     <= '0;
            cmd_size   <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        rsp_op    <= req_op;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        beat_cnt  <= '0;
                        timer     <= T_LOAD;
                        if (legal_op) begin
                            state    <= ISSUE;
                            cmd      <= req_op;
                            cmd_id   <= req_id;
                            cmd_size <= (req_op == OP_NEW) ? req_size : '0;
                            if (req_op == OP_LOAD) begin
                                load_data  <= req_data;
                                load_valid <= 1'b1;
                            end
                        end else begin
                            // Illegal op never reaches the pool.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    load_valid <= 1'b0;
                    load_data  <= '0;
                    cmd_size   <= '0;
                    timer      <= T_LOAD;
                    if (op_q == OP_READ) begin
                        // cmd/cmd_id stay asserted for the whole read.
                        state <= COLLECT;
                    end else begin
                        cmd    <= OP_NONE;
                        cmd_id <= '0;
                        if (op_q == OP_NEW) begin
                            state <= WAIT_ALLOC;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end
                end

                WAIT_ALLOC: begin
                    if (alloc_valid) begin
                        rsp_data  <= {{(64-IDW-1){1'b0}}, alloc_id};
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else if (timer == '0) begin
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                COLLECT: begin
                    if (rdata_valid) begin
                        timer <= T_LOAD;
                        if (beat_cnt < BEATS_MAX) begin
                            rsp_data[int'(beat_cnt)*G +: G] <= rdata;
                            beat_cnt <= beat_cnt + BCW'(1);
                        end else begin
                            // Beats past a full word are dropped but flagged.
                            rsp_err <= 1'b1;
                        end
                        if (rdata_last) begin
                            cmd       <= OP_NONE;
                            cmd_id    <= '0;
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end else if (timer == '0) begin
                        rsp_err   <= 1'b1;
                        cmd       <= OP_NONE;
                        cmd_id    <= '0;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_counters_host.sv
// Self-checking bench for shared_counters_host. Each transaction is turned
// into a per-cycle list of expected outputs by cycle arithmetic, then the
// inputs are played cycle by cycle while a negedge process compares.
module tb_shared_counters_host;

    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [IDW-1:0] req_id;
    logic [IDW:0]   req_size;
    logic [63:0]    req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2:0]     rsp_op;
    logic [63:0]    rsp_data;
    logic           rsp_err;
    logic [2:0]     cmd;
    logic [IDW-1:0] cmd_id;
    logic [IDW:0]   cmd_size;
    logic [63:0]    load_data;
    logic           load_valid;
    logic [IDW:0]   alloc_id;
    logic           alloc_valid;
    logic [3:0]     rdata;
    logic           rdata_valid;
    logic           rdata_last;

    shared_counters_host dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_size(req_size), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cmd(cmd), .cmd_id(cmd_id), .cmd_size(cmd_size),
        .load_data(load_data), .load_valid(load_valid),
        .alloc_id(alloc_id), .alloc_valid(alloc_valid),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]     cmd;
        logic [IDW-1:0] id;
        logic [IDW:0]   size;
        logic           lv;
        logic [63:0]    ld;
        logic           rv;
        logic           rr;
        logic [2:0]     op;
        logic [63:0]    data;
        logic           err;
    } exp_t;

    exp_t       xq[int];
    int         beat_at[int];
    logic [3:0] bv[64];
    int         bg[64];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    exp_t ce;
    logic [2:0]  obs_op;
    logic [63:0] obs_data;
    logic        obs_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] c_e, input logic [IDW-1:0] id_e,
                                input logic [IDW:0] sz_e, input logic lv_e,
                                input logic [63:0] ld_e, input logic rv_e,
                                input logic rr_e, input logic [2:0] op_e,
                                input logic [63:0] d_e, input logic err_e);
        exp_t e;
        e.cmd = c_e;  e.id = id_e;  e.size = sz_e;  e.lv = lv_e;  e.ld = ld_e;
        e.rv = rv_e;  e.rr = rr_e;  e.op = op_e;   e.data = d_e; e.err = err_e;
        return e;
    endfunction

    function automatic exp_t idle_e();
        return mk(3'b000, '0, '0, 1'b0, '0, 1'b0, 1'b1, 3'b000, '0, 1'b0);
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst && xq.exists(cyc)) begin
            ce = xq[cyc];
            chk("cmd", 64'(cmd), 64'(ce.cmd));
            chk("req_ready", 64'(req_ready), 64'(ce.rr));
            chk("rsp_valid", 64'(rsp_valid), 64'(ce.rv));
            chk("load_valid", 64'(load_valid), 64'(ce.lv));
            chk("cmd_size", 64'(cmd_size), 64'(ce.size));
            if (ce.cmd != 3'b000) chk("cmd_id", 64'(cmd_id), 64'(ce.id));
            if (ce.lv) chk("load_data", load_data, ce.ld);
            if (ce.rv) begin
                chk("rsp_op", 64'(rsp_op), 64'(ce.op));
                chk("rsp_data", rsp_data, ce.data);
                chk("rsp_err", 64'(rsp_err), 64'(ce.err));
            end
        end
        if (rsp_valid && rsp_ready) begin
            obs_op   = rsp_op;
            obs_data = rsp_data;
            obs_err  = rsp_err;
        end
    end

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        alloc_valid = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        rdata       = '0;
        alloc_id    = '0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            wait_cyc();
            xq[cyc] = idle_e();
        end
    endtask

    // w: wait cycle (1-based) carrying alloc_valid; above 16 means never.
    // nb: read beats, values/gaps from bv/bg; a gap >= 16 ends in timeout.
    task automatic run_txn(input logic [2:0] op, input logic [IDW-1:0] id,
                           input logic [IDW:0] size, input logic [63:0] data,
                           input logic [IDW:0] aid, input int w, input int nb,
                           input int hold, input bit junk);
        int a, r, c;
        logic [63:0] md;
        logic me;
        bit legal;
        a = cyc;
        legal = (op >= 3'd1) && (op <= 3'd5);
        md = '0;
        me = 1'b0;
        r = a + 2;
        beat_at.delete();
        if (!legal) begin
            r  = a + 1;
            me = 1'b1;
        end else begin
            xq[a+1] = mk(op, id, (op == 3'd2) ? size : '0, op == 3'd4,
                         (op == 3'd4) ? data : '0, 1'b0, 1'b0, '0, '0, 1'b0);
            if (op == 3'd2) begin
                if (w <= 16) begin
                    r  = a + 2 + w;
                    md = {59'b0, aid};
                end else begin
                    r  = a + 18;
                    me = 1'b1;
                end
                for (int k = a + 2; k < r; k++)
                    xq[k] = mk('0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
            end else if (op == 3'd5) begin
                c = a + 2;
                for (int j = 0; j < nb; j++) begin
                    if (bg[j] >= 16) begin
                        r  = c + 16;
                        me = 1'b1;
                        break;
                    end
                    c = c + bg[j];
                    beat_at[c] = j;
                    if (j < 16) md = md | (64'(bv[j]) << (4 * j));
                    else        me = 1'b1;
                    if (j == nb - 1) begin
                        r = c + 1;
                        break;
                    end
                    c++;
                end
                for (int k = a + 2; k < r; k++)
                    xq[k] = mk(3'b101, id, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
            end
        end
        for (int k = r; k <= r + hold; k++)
            xq[k] = mk('0, '0, '0, 1'b0, '0, 1'b1, 1'b0, op, md, me);
        xq[r+hold+1] = idle_e();

        for (int k = a; k <= r + hold; k++) begin
            req_valid = (k == a);
            if (k == a) begin
                req_op = op; req_id = id; req_size = size; req_data = data;
            end
            alloc_valid = 1'b0;
            alloc_id    = (IDW+1)'($urandom);
            if (legal && op == 3'd2) begin
                if (k == a + 1 && junk) alloc_valid = 1'b1;
                if (w <= 16 && k == a + 1 + w) begin
                    alloc_valid = 1'b1;
                    alloc_id    = aid;
                end
            end
            rdata_valid = 1'b0;
            rdata_last  = 1'b0;
            rdata       = 4'($urandom);
            if (beat_at.exists(k)) begin
                rdata_valid = 1'b1;
                rdata       = bv[beat_at[k]];
                rdata_last  = (beat_at[k] == nb - 1);
            end else if (k == a + 1 && junk) begin
                rdata_valid = 1'b1;
                rdata_last  = 1'b1;
            end
            if (k == r + hold)  rsp_ready = 1'b1;
            else if (k < r)     rsp_ready = 1'($urandom_range(0, 1));
            else                rsp_ready = 1'b0;
            wait_cyc();
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op_r, w_r, nb_r;
        rst = 1'b1;
        req_op = '0; req_id = '0; req_size = '0; req_data = '0;
        clear_inputs();
        repeat (3) wait_cyc();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_op", 64'(rsp_op), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_cmd", 64'(cmd), 64'd0);
        chk("rst_cmd_id", 64'(cmd_id), 64'd0);
        chk("rst_cmd_size", 64'(cmd_size), 64'd0);
        chk("rst_load_data", load_data, 64'd0);
        chk("rst_load_valid", 64'(load_valid), 64'd0);
        rst = 1'b0;
        wait_cyc();
        chk_en = 1'b1;
        xq[cyc] = idle_e();
        gap(1);

        // New counter, size 3, id 0 returned after 2 wait cycles.
        run_txn(3'b010, 4'd0, 5'd3, '0, 5'd0, 2, 0, 0, 1'b1);
        chk("lit_new_data", obs_data, 64'd0);
        chk("lit_new_err", 64'(obs_err), 64'd0);
        gap(1);
        // Increment with the response held off for 5 cycles.
        run_txn(3'b001, 4'd0, '0, '0, '0, 0, 0, 5, 1'b0);
        chk("lit_inc_op", 64'(obs_op), 64'd1);
        // Read: beats 5, A, 3.
        bv[0] = 4'h5; bv[1] = 4'hA; bv[2] = 4'h3;
        bg[0] = 0; bg[1] = 0; bg[2] = 0;
        run_txn(3'b101, 4'd0, '0, '0, '0, 0, 3, 0, 1'b1);
        chk("lit_read_data", obs_data, 64'h3A5);
        chk("lit_read_err", 64'(obs_err), 64'd0);
        // Load.
        run_txn(3'b100, 4'd0, '0, 64'hAAAA_AAAA_AAAA_AAAA, '0, 0, 0, 1, 1'b0);
        chk("lit_load_err", 64'(obs_err), 64'd0);
        // New counter that is never answered.
        run_txn(3'b010, 4'd2, 5'd4, '0, '0, 99, 0, 0, 1'b0);
        chk("lit_alloc_timeout", 64'(obs_err), 64'd1);
        // Read with 17 beats: the 17th overflows.
        for (int j = 0; j < 17; j++) begin
            bv[j] = 4'(j);
            bg[j] = 0;
        end
        run_txn(3'b101, 4'd1, '0, '0, '0, 0, 17, 0, 1'b0);
        chk("lit_ovf_data", obs_data, 64'hFEDC_BA98_7654_3210);
        chk("lit_ovf_err", 64'(obs_err), 64'd1);
        // Read that stalls after one beat.
        bv[0] = 4'h9; bg[0] = 0; bg[1] = 20;
        run_txn(3'b101, 4'd3, '0, '0, '0, 0, 4, 0, 1'b0);
        chk("lit_read_timeout_data", obs_data, 64'h9);
        chk("lit_read_timeout_err", 64'(obs_err), 64'd1);
        // Illegal op.
        run_txn(3'b111, 4'd0, '0, '0, '0, 0, 0, 2, 1'b0);
        chk("lit_illegal_err", 64'(obs_err), 64'd1);

        for (int t = 0; t < 80; t++) begin
            op_r = $urandom_range(0, 7);
            w_r  = $urandom_range(1, 19);
            nb_r = $urandom_range(1, 19);
            for (int j = 0; j < 64; j++) begin
                bv[j] = 4'($urandom);
                bg[j] = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 2);
            end
            run_txn(3'(op_r), 4'($urandom_range(0, 9)), 5'($urandom_range(1, 10)),
                    {$urandom, $urandom}, 5'($urandom), w_r, nb_r,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            gap($urandom_range(0, 2));
        end

        // Reset in the middle of a read.
        chk_en = 1'b0;
        req_valid = 1'b1; req_op = 3'b101; req_id = 4'd5;
        wait_cyc();
        req_valid = 1'b0;
        wait_cyc();
        rdata_valid = 1'b1; rdata = 4'h7;
        wait_cyc();
        rdata_valid = 1'b0;
        rst = 1'b1;
        wait_cyc();
        rst = 1'b0;
        chk("abort_cmd", 64'(cmd), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        xq[cyc] = idle_e();
        chk_en = 1'b1;
        gap(1);
        run_txn(3'b001, 4'd7, '0, '0, '0, 0, 0, 0, 1'b0);
        chk("lit_post_abort_op", 64'(obs_op), 64'd1);
        chk("lit_post_abort_err", 64'(obs_err), 64'd0);
        gap(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
